// File: rtl/l2c_pkg.sv
// Shared types for the ifmap preheat controller: layer modes, FSM states, pop-count width helper.
package l2c_pkg;

    typedef enum logic [1:0] {
        PW   = 2'd0,
        DW   = 2'd1,
        CONV = 2'd2,
        RSVD = 2'd3
    } layer_type_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Bits needed to hold NUM_FIFO+K_MAX-1, the largest pop count the block can produce.
    function automatic int pop_w_req(input int num_fifo, input int k_max);
        return $clog2(num_fifo + k_max);
    endfunction

endpackage

// File: rtl/l2c_preheat_ctrl_if.sv
// Bundle between the layer controller / ifmap FIFO bank (master) and the preheat controller (slave).
interface l2c_preheat_ctrl_if #(
    parameter int NUM_FIFO = 32,
    parameter int K_MAX    = 3,
    parameter int POP_W    = 8,
    parameter int TO_W     = 16
);
    localparam int KW = $clog2(K_MAX + 1);

    logic                            start_i;
    logic                            abort_i;
    logic [1:0]                      layer_type_i;
    logic [KW-1:0]                   kernel_i;
    logic [NUM_FIFO-1:0]             row_mask_i;
    logic [TO_W-1:0]                 timeout_i;
    logic [NUM_FIFO-1:0]             fifo_done_i;
    logic [NUM_FIFO-1:0]             need_pop_o;
    logic [NUM_FIFO-1:0][POP_W-1:0]  pop_num_o;
    logic                            busy_o;
    logic                            done_o;
    logic                            err_o;

    modport master (
        output start_i, abort_i, layer_type_i, kernel_i, row_mask_i, timeout_i, fifo_done_i,
        input  need_pop_o, pop_num_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, abort_i, layer_type_i, kernel_i, row_mask_i, timeout_i, fifo_done_i,
        output need_pop_o, pop_num_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/l2c_pop_num_calc.sv
// CALC-phase row walker: one row per cycle, fills the pop-count register file and the effective-active mask.
module l2c_pop_num_calc
    import l2c_pkg::*;
#(
    parameter int NUM_FIFO = 32,
    parameter int K_MAX    = 3,
    parameter int POP_W    = 8,
    localparam int KW      = $clog2(K_MAX + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    input  layer_type_e                    ltype,
    input  logic [KW-1:0]                  k,
    input  logic [NUM_FIFO-1:0]            mask,
    output logic [NUM_FIFO-1:0][POP_W-1:0] pop_num,
    output logic [NUM_FIFO-1:0]            eff_act,
    output logic                           last
);
    localparam int RW = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
    localparam logic [POP_W:0] MAXV = {1'b0, {POP_W{1'b1}}};

    logic [RW-1:0]    row;
    logic [KW-1:0]    idx;
    logic [POP_W:0]   grp;      // K*g: base of the current depthwise group
    logic             grp_ok;
    logic             grp_ok_now;
    logic             act;
    logic [POP_W+1:0] grp_sum;
    logic [POP_W:0]   grp_sat;
    logic [POP_W-1:0] wdata;

    always_comb begin
        // A group is complete only if its last row still fits; decided once at the group's first row.
        grp_ok_now = (idx == '0) ? ((int'(row) + int'(k)) <= NUM_FIFO) : grp_ok;
        grp_sum    = {1'b0, grp} + (POP_W+2)'(k);
        grp_sat    = (grp_sum > (POP_W+2)'(MAXV)) ? MAXV : grp_sum[POP_W:0];
        act        = 1'b0;
        wdata      = '0;
        case (ltype)
            PW:      begin act = mask[row];              wdata = POP_W'(1);           end
            CONV:    begin act = mask[row];              wdata = POP_W'(k);           end
            DW:      begin act = mask[row] & grp_ok_now; wdata = grp_sat[POP_W-1:0];  end
            default: ;
        endcase
        if (!act) wdata = '0;
    end

    assign last = (row == RW'(NUM_FIFO - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row     <= '0;
            idx     <= '0;
            grp     <= '0;
            grp_ok  <= 1'b0;
            pop_num <= '0;
            eff_act <= '0;
        end else if (en) begin
            pop_num[row] <= wdata;
            eff_act[row] <= act;
            grp_ok       <= grp_ok_now;
            row          <= row + RW'(1);
            if (idx == k - KW'(1)) begin
                idx <= '0;
                grp <= grp_sat;
            end else begin
                idx <= idx + KW'(1);
            end
        end
    end

endmodule

// File: rtl/l2c_preheat_ctrl.sv
// Preheat controller: computes per-row pop counts, issues one pop request, waits for every active FIFO.
module l2c_preheat_ctrl
    import l2c_pkg::*;
#(
    parameter int NUM_FIFO = 32,
    parameter int K_MAX    = 3,
    parameter int POP_W    = 8,
    parameter int TO_W     = 16
) (
    input logic               clk,
    input logic               rst,
    l2c_preheat_ctrl_if.slave bus
);
    localparam int KW = $clog2(K_MAX + 1);

    if (K_MAX < 1) begin : g_chk_kmax
        $error("l2c_preheat_ctrl: K_MAX must be >= 1");
    end
    if (POP_W < pop_w_req(NUM_FIFO, K_MAX)) begin : g_chk_popw
        $error("l2c_preheat_ctrl: POP_W cannot hold NUM_FIFO+K_MAX-1");
    end

    state_e                         state;
    layer_type_e                    ltype;
    logic [KW-1:0]                  k;
    logic [NUM_FIFO-1:0]            mask;
    logic [NUM_FIFO-1:0]            sticky;
    logic [NUM_FIFO-1:0]            seen;
    logic [NUM_FIFO-1:0]            eff_act;
    logic [NUM_FIFO-1:0][POP_W-1:0] pop_reg;
    logic [TO_W-1:0]                to_lim;
    logic [TO_W-1:0]                to_cnt;
    logic                           err;
    logic                           accept, bad, last, complete, expire;

    assign accept   = (state == S_IDLE) && bus.start_i;
    assign bad      = (ltype == RSVD) || ((ltype != PW) && ((k == '0) || (int'(k) > K_MAX)));
    assign seen     = sticky | (bus.fifo_done_i & eff_act);
    assign complete = (seen == eff_act);
    assign expire   = (to_lim != '0) && ((to_cnt + TO_W'(1)) == to_lim);

    l2c_pop_num_calc #(.NUM_FIFO(NUM_FIFO), .K_MAX(K_MAX), .POP_W(POP_W)) u_calc (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      ((state == S_CALC) && !bad),
        .ltype   (ltype),
        .k       (k),
        .mask    (mask),
        .pop_num (pop_reg),
        .eff_act (eff_act),
        .last    (last)
    );

    always_comb begin
        bus.need_pop_o = '0;
        if ((state == S_ISSUE) && !bus.abort_i) bus.need_pop_o = eff_act;
    end

    assign bus.pop_num_o = (state == S_CALC) ? '0 : pop_reg;
    assign bus.busy_o    = (state != S_IDLE);
    assign bus.done_o    = (state == S_DONE);
    assign bus.err_o     = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ltype  <= PW;
            k      <= '0;
            mask   <= '0;
            to_lim <= '0;
            to_cnt <= '0;
            sticky <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start_i) begin
                    ltype  <= layer_type_e'(bus.layer_type_i);
                    k      <= bus.kernel_i;
                    mask   <= bus.row_mask_i;
                    to_lim <= bus.timeout_i;
                    to_cnt <= '0;
                    sticky <= '0;
                    err    <= 1'b0;
                    state  <= S_CALC;
                end
                S_CALC: begin
                    if (bus.abort_i)  state <= S_IDLE;
                    else if (bad)     begin state <= S_DONE; err <= 1'b1; end
                    else if (last)    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (bus.abort_i) state <= S_IDLE;
                    else begin
                        sticky <= bus.fifo_done_i & eff_act;
                        to_cnt <= '0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.abort_i) state <= S_IDLE;
                    else begin
                        sticky <= seen;
                        to_cnt <= to_cnt + TO_W'(1);
                        // Completion is checked first so a same-cycle timeout leaves err clear.
                        if (complete)    state <= S_DONE;
                        else if (expire) begin state <= S_DONE; err <= 1'b1; end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2c_preheat_ctrl.sv
// Randomized bench for l2c_preheat_ctrl against a row-formula reference model.
module tb_l2c_preheat_ctrl;
    localparam int NF  = 32;
    localparam int KMX = 3;
    localparam int PWD = 8;
    localparam int TWD = 16;
    localparam int ISS = 1 + NF;   // ISSUE cycle relative to the start cycle

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    l2c_preheat_ctrl_if #(.NUM_FIFO(NF), .K_MAX(KMX), .POP_W(PWD), .TO_W(TWD)) bus();

    l2c_preheat_ctrl #(.NUM_FIFO(NF), .K_MAX(KMX), .POP_W(PWD), .TO_W(TWD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NF-1:0][PWD-1:0] m_pop;
    logic [NF-1:0]          m_eff;
    int                     arr [NF];   // done arrival offset from ISSUE per row, -1 = never

    task automatic model(input int lt, input int k, input logic [NF-1:0] mask);
        int v;
        m_pop = '0;
        m_eff = '0;
        for (int r = 0; r < NF; r++) begin
            v = -1;
            if (mask[r]) begin
                if (lt == 0) v = 1;
                else if (lt == 2) v = k;
                else if (lt == 1 && r < k * (NF / k)) v = k * (r / k + 1);
            end
            if (v >= 0) begin
                m_eff[r] = 1'b1;
                m_pop[r] = (v > 255) ? 8'hFF : 8'(v);
            end
        end
    endtask

    task automatic set_arr(input int v);
        for (int b = 0; b < NF; b++) arr[b] = v;
    endtask

    task automatic idle_inputs();
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.layer_type_i = '0; bus.kernel_i = '0;
        bus.row_mask_i = '0; bus.timeout_i = '0; bus.fifo_done_i = '0;
    endtask

    // ab: cycle (>=1) at which abort_i and start_i are both pulsed, 0 = none; ab0: abort with the start.
    task automatic run_case(input string name, input int lt, input int k, input logic [NF-1:0] mask,
                            input int to, input int ab, input bit ab0);
        bit bad, never, aborted, experr;
        int last_off, dcyc, endc;
        logic [3:0] e_ctl, g_ctl;
        logic [NF-1:0] e_need, fd;
        logic [NF-1:0][PWD-1:0] e_pop;

        bad = (lt == 3) || (lt != 0 && (k == 0 || k > KMX));
        if (bad) begin m_pop = '0; m_eff = '0; end
        else model(lt, k, mask);
        never = 1'b0;
        last_off = 1;
        for (int b = 0; b < NF; b++)
            if (m_eff[b]) begin
                if (arr[b] < 0) never = 1'b1;
                else if (arr[b] > last_off) last_off = arr[b];
            end
        if (bad) begin dcyc = 2; experr = 1'b1; end
        else if (!never && (to == 0 || last_off <= to)) begin dcyc = ISS + last_off + 1; experr = 1'b0; end
        else if (to != 0) begin dcyc = ISS + to + 1; experr = 1'b1; end
        else begin dcyc = 1000; experr = 1'b0; end
        aborted = (ab >= 1) && (ab < dcyc);
        endc = aborted ? ab : dcyc;
        if (endc > 200) begin
            fails++;
            $display("FAIL %s setup: case would not terminate (end=%0d)", name, endc);
            return;
        end

        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.abort_i = ab0; bus.layer_type_i = 2'(lt); bus.kernel_i = 2'(k);
        bus.row_mask_i = mask; bus.timeout_i = TWD'(to); bus.fifo_done_i = $urandom;
        @(negedge clk);
        tests++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            fails++;
            $display("FAIL %s start_idle: busy=%b done=%b required 0 0", name, bus.busy_o, bus.done_o);
        end

        for (int c = 1; c <= endc + 2; c++) begin
            @(posedge clk); #1;
            bus.start_i = (c == ab);
            bus.abort_i = (c == ab);
            bus.layer_type_i = 2'($urandom); bus.kernel_i = 2'($urandom);
            bus.row_mask_i = $urandom; bus.timeout_i = TWD'($urandom);
            fd = $urandom;
            fd = fd & ~m_eff;
            for (int b = 0; b < NF; b++)
                if (m_eff[b] && arr[b] >= 0 && c == ISS + arr[b]) fd[b] = 1'b1;
            bus.fifo_done_i = fd;
            @(negedge clk);
            e_need = (!bad && c == ISS && !(aborted && ab <= ISS)) ? m_eff : '0;
            e_ctl = {c <= endc, !aborted && c == dcyc, (!aborted && c >= dcyc) ? experr : 1'b0, 1'b0};
            g_ctl = {bus.busy_o, bus.done_o, bus.err_o, 1'b0};
            tests++;
            if (g_ctl !== e_ctl || bus.need_pop_o !== e_need) begin
                fails++;
                $display("FAIL %s ctl c=%0d: busy/done/err=%b need=%h required %b need=%h",
                         name, c, g_ctl[3:1], bus.need_pop_o, e_ctl[3:1], e_need);
            end
            if (!(aborted && c > ab)) begin
                e_pop = (!bad && c >= ISS) ? m_pop : '0;
                tests++;
                if (bus.pop_num_o !== e_pop) begin
                    fails++;
                    $display("FAIL %s pop c=%0d: got %h required %h", name, c, bus.pop_num_o, e_pop);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus.busy_o, bus.done_o, bus.err_o} !== 3'b000 || bus.need_pop_o !== '0 || bus.pop_num_o !== '0) begin
            fails++;
            $display("FAIL reset: busy/done/err=%b need=%h pop=%h required all 0",
                     {bus.busy_o, bus.done_o, bus.err_o}, bus.need_pop_o, bus.pop_num_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_pointwise();
        set_arr(2);
        run_case("pw_full", 0, 1, '1, 0, 0, 0);
        set_arr(1);
        run_case("pw_nomask", 0, 0, '0, 0, 0, 0);
    endtask

    task automatic test_depthwise();
        for (int b = 0; b < NF; b++) arr[b] = $urandom_range(0, 5);
        run_case("dw_k3", 1, 3, '1, 0, 0, 0);
        set_arr(-1);
        arr[4] = 0; arr[5] = 1; arr[6] = 2; arr[7] = 3;
        run_case("dw_k2_sparse", 1, 2, 32'h0000_00F0, 0, 0, 0);
        for (int b = 0; b < NF; b++) arr[b] = $urandom_range(0, 3);
        run_case("dw_k1", 1, 1, $urandom, 0, 0, 0);
    endtask

    task automatic test_timeout();
        set_arr(-1);
        run_case("conv_timeout", 2, 3, '1, 10, 0, 0);
        set_arr(3);
        run_case("tie_complete_wins", 2, 3, '1, 3, 0, 0);
        set_arr(4);
        run_case("timeout_first", 2, 2, $urandom, 3, 0, 0);
    endtask

    task automatic test_bad_config();
        run_case("bad_rsvd", 3, 2, '1, 0, 0, 0);
        run_case("bad_dw_k0", 1, 0, '1, 0, 0, 0);
        set_arr(1);
        run_case("err_cleared", 0, 0, '1, 0, 0, 0);
    endtask

    task automatic test_abort();
        set_arr(-1);
        run_case("abort_wait", 0, 1, '1, 0, ISS + 3, 0);
        set_arr(1);
        run_case("fresh_after_abort", 2, 2, '1, 0, 0, 0);
        run_case("abort_calc", 1, 3, '1, 0, 10, 0);
        run_case("abort_issue", 0, 1, '1, 0, ISS, 0);
        run_case("abort_in_done", 0, 1, '1, 0, ISS + 2, 0);
        run_case("abort_in_idle", 2, 1, '1, 0, 0, 1);
    endtask

    task automatic test_reset_mid_calc();
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.layer_type_i = 2'd0; bus.row_mask_i = '1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if ({bus.busy_o, bus.done_o, bus.err_o} !== 3'b000 || bus.need_pop_o !== '0 || bus.pop_num_o !== '0) begin
                fails++;
                $display("FAIL reset_mid_calc c=%0d: busy/done/err=%b need=%h required all 0",
                         c, {bus.busy_o, bus.done_o, bus.err_o}, bus.need_pop_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int lt, k, to, ab;
        for (int i = 0; i < 20; i++) begin
            lt = $urandom_range(0, 3);
            k  = $urandom_range(0, 3);
            to = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8);
            for (int b = 0; b < NF; b++)
                arr[b] = (to != 0 && $urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 6);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, ISS + 6) : 0;
            run_case($sformatf("rand%0d", i), lt, k, $urandom, to, ab, 1'($urandom));
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_pointwise();
        test_depthwise();
        test_timeout();
        test_bad_config();
        test_abort();
        test_reset_mid_calc();
        set_arr(1);
        run_case("after_reset", 1, 2, '1, 0, 0, 0);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l2c_preheat_ctrl.md
Name: l2c_preheat_ctrl

Overview:
Parametrised preheat controller in the token engine. It drives each ifmap FIFO to push its initial data into its PE row before compute starts.
- Per-row pop counts are computed from a runtime kernel size, layer mode and active-row mask.
- A one-cycle pop request is issued, then the controller waits for the sticky done bit of every active FIFO.
- It reports completion, timeout or abort.
- It sits between the layer controller, which issues start, and the ifmap FIFO bank.

Parameters:
NUM_FIFO, 32, number of ifmap FIFOs / PE rows
K_MAX, 3, largest supported kernel size (must be ≥1)
POP_W, 8, width of each pop count; must hold NUM_FIFO+K_MAX-1
TO_W, 16, width of the timeout counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start_i  in  1  one-cycle start pulse; ignored unless busy_o=0
abort_i  in  1  cancel in-flight preheat
layer_type_i  in  2  0 pointwise, 1 depthwise, 2 standard conv, 3 reserved; sampled on start
kernel_i  in  $clog2(K_MAX+1)  kernel size K, sampled on start
row_mask_i  in  NUM_FIFO  active-row mask, sampled on start
timeout_i  in  TO_W  maximum WAIT cycles; 0 disables the timeout; sampled on start
fifo_done_i  in  NUM_FIFO  per-FIFO done pulses or levels
need_pop_o  out  NUM_FIFO  one-cycle pop request, one bit per FIFO
pop_num_o  out  NUM_FIFO x POP_W  per-FIFO pop count
busy_o  out  1  high from the cycle after accepted start until return to IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky error (bad config or timeout); cleared by the next accepted start

Behaviour:
- Reset values: all outputs 0, state IDLE, all internal registers 0.
- FSM states: IDLE, CALC, ISSUE, WAIT, DONE.
- IDLE
  - start_i=1 latches type, K, mask and timeout, clears err_o, and goes to CALC.
  - Bad configuration jumps straight to DONE with err_o=1. Bad configuration means:
    - type=3, or
    - K=0 or K>K_MAX when type≠0.
- CALC: walks rows r=0..NUM_FIFO-1, one row per cycle, writing a pop_num register for each row.
  - Masked-off rows get 0.
  - Pointwise: 1.
  - Standard conv: K.
  - Depthwise: K*(g+1), where g=floor(r/K).
    - Computed with a running in-group index and a running group value (no divider).
    - Rows in a trailing incomplete group (r ≥ K*floor(NUM_FIFO/K)) get 0 and are treated as inactive.
  - After row NUM_FIFO-1 the FSM goes to ISSUE.
  - Latency: start at cycle t gives ISSUE at cycle t+1+NUM_FIFO.
- ISSUE, one cycle
  - need_pop_o[r]=1 for every effective-active row, i.e. mask=1 and not in an incomplete group.
  - Go to WAIT.
- pop_num_o: driven from the registers and held stable from ISSUE until the next start. It reads 0 during CALC.
- WAIT: done_sticky |= fifo_done_i & effective_active.
  - Done bits seen in the ISSUE cycle are also captured.
  - When every effective-active bit is set, go to DONE.
  - If there are zero effective-active rows, leave WAIT on the first WAIT cycle.
  - Timeout counter counts WAIT cycles. When timeout_i≠0 and count==timeout_i, set err_o=1 and go to DONE.
  - If completion and timeout happen in the same cycle, completion wins and err_o stays 0.
- DONE: done_o=1 for one cycle, then IDLE.
- Abort: abort_i in CALC, ISSUE or WAIT goes to IDLE next cycle.
  - No done_o, err_o unchanged, need_pop_o forced 0 that cycle.
  - Abort wins over every same-cycle event.
  - Abort in IDLE or DONE is ignored.
- start_i while busy_o=1 is ignored.
- rst asserted mid-operation returns everything to reset values on the next edge.
- Widths: pop counts saturate at 2^POP_W−1. An elaboration assertion checks POP_W.

Decomposition:
- Shared package l2c_pkg holds:
  - layer_type_e: PW=0, DW=1, CONV=2, RSVD=3
  - the FSM state enum
  - the helper function for the required POP_W.
- One sub-module, l2c_pop_num_calc, holds:
  - the CALC-phase row walker: row counter, in-group index, group value
  - the write-enable into the pop_num register file.
- The FSM, done tracking and timeout counter stay in the top module.

Test Plan:
1. NUM_FIFO=32, PW, mask=all 1s, done bits returned 2 cycles after ISSUE → need_pop_o=FFFF_FFFF for exactly one cycle at t+33, all pop_num_o=1, done_o pulse, err_o=0.
2. DW, K=3, full mask → pop_num_o[0..2]=3, [27..29]=30, [30],[31]=0. need_pop_o=3FFF_FFFF. Done waits only on bits 0..29.
3. DW, K=2, mask=0x0000_00F0, done pulses on bits 4..7 in separate cycles (bit 4 during ISSUE) → pop_num_o[4,5]=6, [6,7]=8, others 0. done_o fires after the last pulse.
4. CONV, K=3, timeout_i=10, fifo_done_i never asserted → err_o=1 and done_o after 10 WAIT cycles. The next start clears err_o.
5. type=3, or DW with K=0 → done_o at t+2, err_o=1, need_pop_o never asserted.
6. abort_i during WAIT, then start_i in that same abort cycle, then a fresh start → FSM reaches IDLE, no done_o, the same-cycle start is ignored, and the fresh start runs normally. rst pulse mid-CALC → all outputs 0.
